// File: rtl/sprite_anim_if.sv
// Bundle between the scan/game side and the sprite animation controller.
// Handshake: there is no valid/ready pair; every field is a level sampled on each vga_clk posedge.
interface sprite_anim_if #(
    parameter int ADDR_W = 17,
    parameter int FIDX_W = 2,
    parameter int HOLD_W = 3
);
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              anim_en;
    logic              anim_start;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_on;
    logic [FIDX_W-1:0] frame_idx;
    logic              frame_tick;
    logic [1:0]        dbg_state;
    logic [HOLD_W-1:0] dbg_hold;

    modport master (
        output DrawX, DrawY, blank, pos_x, pos_y, anim_en, anim_start,
        input  rom_address, sprite_on, frame_idx, frame_tick, dbg_state, dbg_hold
    );

    modport slave (
        input  DrawX, DrawY, blank, pos_x, pos_y, anim_en, anim_start,
        output rom_address, sprite_on, frame_idx, frame_tick, dbg_state, dbg_hold
    );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Sprite animation/addressing controller: latches the sprite position once per frame,
// steps animation frames on frame ticks and emits a registered ROM address plus hit flag.
module sprite_anim_ctrl #(
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 32,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int ADDR_W     = 17,
    parameter int FIDX_W     = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1,
    parameter int HOLD_W     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1
) (
    input  logic          vga_clk,
    input  logic          reset_n,
    sprite_anim_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [10:0]       SPR_W_L    = 11'(SPR_W);
    localparam logic [10:0]       SPR_H_L    = 11'(SPR_H);
    localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(NUM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD  = HOLD_W'(FRAME_HOLD - 1);

    state_t            state_q, state_d;
    logic [FIDX_W-1:0] frame_q, frame_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [9:0]        lx_q, ly_q;
    logic              tick_q, tick_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              on_q, on_d;
    logic [10:0]       dx, dy;
    logic              hit;

    assign tick_d = (bus.DrawX == 10'd0) && (bus.DrawY == 10'd480);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            hold_q  <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            tick_q  <= 1'b0;
            addr_q  <= '0;
            on_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            addr_q  <= addr_d;
            on_q    <= on_d;
            // Latch only at vertical blanking so a frame never tears.
            if (tick_q) begin
                lx_q <= bus.pos_x;
                ly_q <= bus.pos_y;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        hold_d  = hold_q;
        if (bus.anim_start) begin
            state_d = RUN;
            frame_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_d = '0;
                    hold_d  = '0;
                    if (bus.anim_en) state_d = RUN;
                end
                RUN: begin
                    if (tick_q) begin
                        if (hold_q == LAST_HOLD) begin
                            hold_d  = '0;
                            frame_d = (frame_q == LAST_FRAME) ? '0 : frame_q + 1'b1;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    if (!bus.anim_en) state_d = PAUSE;
                end
                PAUSE: begin
                    if (bus.anim_en) state_d = RUN;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Bit 10 is the borrow: a scan position left of / above the sprite never wraps into a hit.
    always_comb begin
        dx     = {1'b0, bus.DrawX} - {1'b0, lx_q};
        dy     = {1'b0, bus.DrawY} - {1'b0, ly_q};
        hit    = !dx[10] && !dy[10] && (dx < SPR_W_L) && (dy < SPR_H_L) && bus.blank;
        addr_d = '0;
        on_d   = 1'b0;
        if (hit) begin
            addr_d = ADDR_W'(frame_q) * ADDR_W'(SPR_W * SPR_H)
                   + ADDR_W'(dy) * ADDR_W'(SPR_W)
                   + ADDR_W'(dx);
            on_d   = 1'b1;
        end
    end

    assign bus.rom_address = addr_q;
    assign bus.sprite_on   = on_q;
    assign bus.frame_idx   = frame_q;
    assign bus.frame_tick  = tick_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_hold    = hold_q;
endmodule

// File: tb/tb_sprite_anim_ctrl.sv
// Directed bench for sprite_anim_ctrl with FRAME_HOLD=2 and hand-computed expectations.
module tb_sprite_anim_ctrl;
    localparam int ADDR_W = 17;
    localparam int FIDX_W = 2;
    localparam int HOLD_W = 1;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;

    logic vga_clk;
    logic reset_n;
    int   checks;
    int   errors;

    sprite_anim_if #(.ADDR_W(ADDR_W), .FIDX_W(FIDX_W), .HOLD_W(HOLD_W)) bus ();

    sprite_anim_ctrl #(
        .SPR_W(32), .SPR_H(32), .NUM_FRAMES(4), .FRAME_HOLD(2), .ADDR_W(ADDR_W)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Clock and reset
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs applied 1ns after a posedge are sampled at the next posedge; outputs read 1ns after it.
    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic scan(input int x, input int y, input logic b);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        bus.blank = b;
        step();
    endtask

    task automatic frame_tick_cycle();
        scan(0, 480, 1'b0);
        check("tick_high", {31'd0, bus.frame_tick}, 32'd1);
        scan(1, 480, 1'b0);
        check("tick_low", {31'd0, bus.frame_tick}, 32'd0);
    endtask

    int exp_seq[9] = '{0, 1, 1, 2, 2, 3, 3, 0, 0};

    initial begin
        checks = 0;
        errors = 0;
        reset_n        = 1'b0;
        bus.anim_en    = 1'b1;
        bus.anim_start = 1'b0;
        bus.pos_x      = 10'd0;
        bus.pos_y      = 10'd0;
        bus.DrawX      = 10'd0;
        bus.DrawY      = 10'd480;
        bus.blank      = 1'b1;
        #1;
        repeat (3) step();
        check("rst_addr",  32'(bus.rom_address), 32'd0);
        check("rst_on",    {31'd0, bus.sprite_on}, 32'd0);
        check("rst_frame", 32'(bus.frame_idx), 32'd0);
        check("rst_tick",  {31'd0, bus.frame_tick}, 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(S_IDLE));

        reset_n = 1'b1;
        scan(700, 10, 1'b0);
        check("rel_state", 32'(bus.dbg_state), 32'(S_RUN));
        check("rel_frame", 32'(bus.frame_idx), 32'd0);

        for (int i = 0; i < 9; i++) begin
            frame_tick_cycle();
            check($sformatf("anim_%0d", i + 1), 32'(bus.frame_idx), 32'(exp_seq[i]));
        end

        // Three more ticks reach frame 2 with the new position latched.
        bus.pos_x = 10'd100;
        bus.pos_y = 10'd50;
        repeat (3) frame_tick_cycle();
        check("frame2", 32'(bus.frame_idx), 32'd2);

        scan(110, 60, 1'b1);
        check("addr_hit", 32'(bus.rom_address), 32'd2378);
        check("on_hit",   {31'd0, bus.sprite_on}, 32'd1);
        scan(132, 60, 1'b1);
        check("addr_dx32", 32'(bus.rom_address), 32'd0);
        check("on_dx32",   {31'd0, bus.sprite_on}, 32'd0);
        scan(131, 81, 1'b1);
        check("addr_corner", 32'(bus.rom_address), 32'd3071);
        scan(131, 82, 1'b1);
        check("on_dy32", {31'd0, bus.sprite_on}, 32'd0);
        scan(110, 60, 1'b0);
        check("on_blank", {31'd0, bus.sprite_on}, 32'd0);

        bus.pos_x = 10'd200;
        scan(110, 60, 1'b1);
        check("latch_hold", 32'(bus.rom_address), 32'd2378);
        frame_tick_cycle();
        scan(110, 60, 1'b1);
        check("latch_old_off", {31'd0, bus.sprite_on}, 32'd0);
        scan(210, 60, 1'b1);
        check("latch_new", 32'(bus.rom_address), 32'd2378);

        frame_tick_cycle();
        check("frame3", 32'(bus.frame_idx), 32'd3);
        bus.anim_en = 1'b0;
        scan(700, 10, 1'b0);
        check("pause_state", 32'(bus.dbg_state), 32'(S_PAUSE));
        repeat (5) frame_tick_cycle();
        check("pause_frame", 32'(bus.frame_idx), 32'd3);
        check("pause_hold",  32'(bus.dbg_hold), 32'd0);

        // Restart coinciding with a frame tick, while anim_en is still low.
        bus.pos_x = 10'd630;
        bus.pos_y = 10'd470;
        scan(0, 480, 1'b0);
        check("sim_tick", {31'd0, bus.frame_tick}, 32'd1);
        bus.anim_start = 1'b1;
        scan(1, 480, 1'b0);
        bus.anim_start = 1'b0;
        check("start_frame", 32'(bus.frame_idx), 32'd0);
        check("start_hold",  32'(bus.dbg_hold), 32'd0);
        check("start_state", 32'(bus.dbg_state), 32'(S_RUN));
        bus.anim_en = 1'b1;

        scan(639, 479, 1'b1);
        check("clip_addr", 32'(bus.rom_address), 32'd297);
        check("clip_on",   {31'd0, bus.sprite_on}, 32'd1);
        scan(5, 479, 1'b1);
        check("clip_nowrap", {31'd0, bus.sprite_on}, 32'd0);

        scan(639, 479, 1'b1);
        reset_n = 1'b0;
        scan(639, 479, 1'b1);
        check("midrst_on",   {31'd0, bus.sprite_on}, 32'd0);
        check("midrst_addr", 32'(bus.rom_address), 32'd0);
        reset_n = 1'b1;
        scan(5, 5, 1'b1);
        check("midrst_lx0", 32'(bus.rom_address), 32'd165);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
